// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: divides clk into SCLK half-periods and emits edge/data strobes for a frame.
// Optional inter-frame idle gap is enabled with `define SPI_SCLK_GAP_EN (adds the gap input and GAP state).
module spi_sclk_engine #(
  parameter int unsigned DIV_W = 12,
  parameter int unsigned LEN_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] div,
  input  logic [LEN_W-1:0] len,
  input  logic             cpol,
  input  logic             cpha,
`ifdef SPI_SCLK_GAP_EN
  input  logic [DIV_W-1:0] gap,
`endif
  output logic             sclk,
  output logic             lead_edge,
  output logic             trail_edge,
  output logic             sample,
  output logic             shift,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_cnt
);

`ifdef SPI_SCLK_GAP_EN
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t           state, state_d;
  logic [DIV_W-1:0] cnt, cnt_d;
  logic             phase, phase_d;
  logic [DIV_W-1:0] div_q, div_qd;
  logic [LEN_W-1:0] len_q, len_qd;
  logic             cpol_q, cpol_qd;
  logic             cpha_q, cpha_qd;
  logic             lead_d, trail_d, sample_d, shift_d, busy_d, done_d;
  logic [LEN_W-1:0] bit_cnt_d;
  logic             accept;
  logic             hp_end;
  logic             last_trail;
`ifdef SPI_SCLK_GAP_EN
  logic [DIV_W-1:0] gap_q, gap_qd;
  logic             gap_end;
`endif

  assign accept     = (state == IDLE) && start && !abort && (len != '0);
  assign hp_end     = (cnt == div_q);
  assign last_trail = hp_end && phase && ((bit_cnt + LEN_W'(1)) == len_q);
`ifdef SPI_SCLK_GAP_EN
  assign gap_end    = (cnt == (gap_q - DIV_W'(1)));
`endif

  // Latched polarity holds the idle level steady for the whole frame.
  assign sclk = phase ^ (busy ? cpol_q : cpol);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (abort) state_d = IDLE;
`ifdef SPI_SCLK_GAP_EN
        else if (last_trail) state_d = (gap_q != '0) ? GAP : IDLE;
`else
        else if (last_trail) state_d = IDLE;
`endif
      end
`ifdef SPI_SCLK_GAP_EN
      GAP: if (abort || gap_end) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cnt_d     = cnt;
    phase_d   = phase;
    bit_cnt_d = bit_cnt;
    div_qd    = div_q;
    len_qd    = len_q;
    cpol_qd   = cpol_q;
    cpha_qd   = cpha_q;
`ifdef SPI_SCLK_GAP_EN
    gap_qd    = gap_q;
`endif
    lead_d    = 1'b0;
    trail_d   = 1'b0;
    sample_d  = 1'b0;
    shift_d   = 1'b0;
    busy_d    = (state_d != IDLE);
    done_d    = (state != IDLE) && (state_d == IDLE) && !abort;
    case (state)
      IDLE: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (accept) begin
          div_qd    = div;
          len_qd    = len;
          cpol_qd   = cpol;
          cpha_qd   = cpha;
`ifdef SPI_SCLK_GAP_EN
          gap_qd    = gap;
`endif
          bit_cnt_d = '0;
        end
      end
      RUN: begin
        if (abort) begin
          cnt_d   = '0;
          phase_d = 1'b0;
        end else if (hp_end) begin
          cnt_d   = '0;
          phase_d = ~phase;
          if (!phase) begin
            lead_d   = 1'b1;
            sample_d = ~cpha_q;
            shift_d  = cpha_q;
          end else begin
            trail_d   = 1'b1;
            bit_cnt_d = bit_cnt + LEN_W'(1);
            sample_d  = cpha_q;
            shift_d   = ~cpha_q && !last_trail;
          end
        end else begin
          cnt_d = cnt + DIV_W'(1);
        end
      end
`ifdef SPI_SCLK_GAP_EN
      GAP: begin
        if (abort || gap_end) cnt_d = '0;
        else                  cnt_d = cnt + DIV_W'(1);
      end
`endif
      default: begin
        cnt_d   = '0;
        phase_d = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      phase      <= 1'b0;
      bit_cnt    <= '0;
      div_q      <= '0;
      len_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
`ifdef SPI_SCLK_GAP_EN
      gap_q      <= '0;
`endif
      lead_edge  <= 1'b0;
      trail_edge <= 1'b0;
      sample     <= 1'b0;
      shift      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      phase      <= phase_d;
      bit_cnt    <= bit_cnt_d;
      div_q      <= div_qd;
      len_q      <= len_qd;
      cpol_q     <= cpol_qd;
      cpha_q     <= cpha_qd;
`ifdef SPI_SCLK_GAP_EN
      gap_q      <= gap_qd;
`endif
      lead_edge  <= lead_d;
      trail_edge <= trail_d;
      sample     <= sample_d;
      shift      <= shift_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Self-checking bench for spi_sclk_engine against a cycle-timeline model of a frame.
// With SPI_SCLK_GAP_EN defined the gap port and gap scenario are also exercised.
module tb_spi_sclk_engine;
  localparam int unsigned DIV_W = 12;
  localparam int unsigned LEN_W = 6;
  localparam int unsigned VW    = LEN_W + 7;

  logic             clk = 1'b0;
  logic             reset, start, abort, cpol, cpha;
  logic [DIV_W-1:0] div;
  logic [LEN_W-1:0] len;
`ifdef SPI_SCLK_GAP_EN
  logic [DIV_W-1:0] gap;
`endif
  logic             sclk, lead_edge, trail_edge, sample, shift, busy, done;
  logic [LEN_W-1:0] bit_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [LEN_W-1:0] last_bc;

  spi_sclk_engine #(.DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .div(div), .len(len),
    .cpol(cpol), .cpha(cpha),
`ifdef SPI_SCLK_GAP_EN
    .gap(gap),
`endif
    .sclk(sclk), .lead_edge(lead_edge), .trail_edge(trail_edge), .sample(sample),
    .shift(shift), .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs t clocks after the start-accepting edge: half-period hp = d+1,
  // edge m at t = m*hp (odd m leading, even m trailing), 2n edges, then g gap cycles.
  function automatic logic [VW-1:0] model(input int t, input int d, input int n, input int g,
                                          input bit pol, input bit pha, input bit live_pol);
    int hp, total, m, bc;
    bit edge_now, ld, tr, bsy, dn, ph, sc, smp, shf;
    hp       = d + 1;
    total    = 2 * n * hp;
    m        = t / hp;
    edge_now = (t % hp == 0) && (m >= 1) && (m <= 2 * n);
    ld       = edge_now && (m % 2 == 1);
    tr       = edge_now && (m % 2 == 0);
    bsy      = (t < total + g);
    dn       = (t == total + g);
    ph       = (t < total) ? bit'(m % 2) : 1'b0;
    sc       = bsy ? (ph ^ pol) : live_pol;
    smp      = pha ? tr : ld;
    shf      = pha ? ld : (tr && (m < 2 * n));
    bc       = (m / 2 > n) ? n : m / 2;
    return {sc, ld, tr, smp, shf, bsy, dn, LEN_W'(bc)};
  endfunction

  // Drive one frame and compare every cycle; optional abort right after trail edge abort_at.
  task automatic run_frame(input int d, input int n, input bit pol, input bit pha,
                           input int abort_at, input int g, input bit noise, input string name);
    int total, end_t;
    logic [VW-1:0] exp_v, got;
    total = 2 * n * (d + 1);
    end_t = total + g;
    div = DIV_W'(d); len = LEN_W'(n); cpol = pol; cpha = pha; abort = 1'b0; start = 1'b1;
`ifdef SPI_SCLK_GAP_EN
    gap = DIV_W'(g);
`endif
    step();
    start = 1'b0;
    for (int t = 0; t <= end_t; t++) begin
      exp_v = model(t, d, n, g, pol, pha, cpol);
      got   = {sclk, lead_edge, trail_edge, sample, shift, busy, done, bit_cnt};
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL %s t=%0d got=%b expected=%b", name, t, got, exp_v);
      end
      if (abort_at > 0 && t == 2 * abort_at * (d + 1)) begin
        abort = 1'b1; start = 1'b0;
        step();
        abort = 1'b0;
        exp_v = {cpol, 6'b000000, LEN_W'(abort_at)};
        got   = {sclk, lead_edge, trail_edge, sample, shift, busy, done, bit_cnt};
        n_cmp++;
        if (got !== exp_v) begin
          n_bad++;
          $display("FAIL %s_abort got=%b expected=%b", name, got, exp_v);
        end
        last_bc = LEN_W'(abort_at);
        return;
      end
      if (t < end_t) begin
        if (noise) begin
          div = DIV_W'($urandom); len = LEN_W'($urandom);
          cpol = 1'($urandom); cpha = 1'($urandom); start = 1'($urandom);
`ifdef SPI_SCLK_GAP_EN
          gap = DIV_W'($urandom);
`endif
        end
        step();
      end
    end
    start = 1'b0;
    last_bc = LEN_W'(n);
    step();
    exp_v = {cpol, 6'b000000, last_bc};
    got   = {sclk, lead_edge, trail_edge, sample, shift, busy, done, bit_cnt};
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s_post got=%b expected=%b", name, got, exp_v);
    end
  endtask

  task automatic test_reset();
    logic [VW-1:0] exp_v, got;
    start = 0; abort = 0; div = '0; len = '0; cpol = 1'b1; cpha = 0;
`ifdef SPI_SCLK_GAP_EN
    gap = '0;
`endif
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    exp_v = {1'b1, 6'b000000, LEN_W'(0)};
    got   = {sclk, lead_edge, trail_edge, sample, shift, busy, done, bit_cnt};
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL reset_async got=%b expected=%b", got, exp_v);
    end
    step(); step();
    cpol = 1'b0; #1;
    exp_v = {1'b0, 6'b000000, LEN_W'(0)};
    got   = {sclk, lead_edge, trail_edge, sample, shift, busy, done, bit_cnt};
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL reset_hold got=%b expected=%b", got, exp_v);
    end
    reset = 1'b1;
    step();
    last_bc = '0;
  endtask

  task automatic test_basic();
    run_frame(0, 8, 1'b0, 1'b0, -1, 0, 1'b0, "mode0_div0");
    run_frame(3, 2, 1'b1, 1'b1, -1, 0, 1'b0, "mode3_div3");
  endtask

  task automatic test_abort();
    run_frame(2, 8, 1'b0, 1'b0, 3, 0, 1'b0, "abort3");
    run_frame(1, 3, 1'b1, 1'b0, -1, 0, 1'b0, "after_abort");
  endtask

  task automatic test_ignored();
    logic [VW-1:0] exp_v, got;
    len = '0; div = DIV_W'(1); cpol = 1'b0; start = 1'b1;
    step(); step();
    start = 1'b0;
    exp_v = {1'b0, 6'b000000, last_bc};
    got   = {sclk, lead_edge, trail_edge, sample, shift, busy, done, bit_cnt};
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL len0_start got=%b expected=%b", got, exp_v);
    end
    len = LEN_W'(4); cpol = 1'b1; start = 1'b1; abort = 1'b1;
    step(); step();
    start = 1'b0; abort = 1'b0;
    exp_v = {1'b1, 6'b000000, last_bc};
    got   = {sclk, lead_edge, trail_edge, sample, shift, busy, done, bit_cnt};
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL start_abort got=%b expected=%b", got, exp_v);
    end
    run_frame(2, 5, 1'b0, 1'b1, -1, 0, 1'b1, "noisy_inputs");
  endtask

  task automatic test_max_div();
    run_frame(int'({DIV_W{1'b1}}), 1, 1'b0, 1'b0, -1, 0, 1'b0, "max_div");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      int d, n, ab, g;
      d  = $urandom_range(0, 7);
      n  = $urandom_range(1, 12);
      ab = ((n >= 2) && ($urandom_range(0, 3) == 0)) ? $urandom_range(1, n - 1) : -1;
`ifdef SPI_SCLK_GAP_EN
      g  = $urandom_range(0, 6);
`else
      g  = 0;
`endif
      run_frame(d, n, 1'($urandom), 1'($urandom), ab, g, 1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] exp_v, got;
    div = DIV_W'(2); len = LEN_W'(8); cpol = 1'b1; cpha = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (15) step();
    exp_v = model(15, 2, 8, 0, 1'b1, 1'b0, 1'b1);
    got   = {sclk, lead_edge, trail_edge, sample, shift, busy, done, bit_cnt};
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL reset_mid_pre got=%b expected=%b", got, exp_v);
    end
    reset = 1'b0;
    #2;
    exp_v = {1'b1, 6'b000000, LEN_W'(0)};
    got   = {sclk, lead_edge, trail_edge, sample, shift, busy, done, bit_cnt};
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL reset_mid got=%b expected=%b", got, exp_v);
    end
    reset = 1'b1;
    step();
    last_bc = '0;
    got = {sclk, lead_edge, trail_edge, sample, shift, busy, done, bit_cnt};
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL reset_mid_release got=%b expected=%b", got, exp_v);
    end
  endtask

`ifdef SPI_SCLK_GAP_EN
  task automatic test_gap();
    run_frame(1, 4, 1'b0, 1'b0, -1, 5, 1'b0, "gap5");
    run_frame(1, 4, 1'b1, 1'b1, -1, 0, 1'b0, "gap0");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_ignored();
    test_max_div();
`ifdef SPI_SCLK_GAP_EN
    test_gap();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
